// File: rtl/ahb2apb_bridge_nch.sv
// AHB-Lite slave to multi-slave APB master bridge with wait states and error mapping.
// Optional AHB2APB_PSTRB_EN adds a registered PSTRB byte-lane output.
module ahb2apb_bridge_nch #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SEL_LSB        = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic                             HSEL,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic                             HWRITE,
    input  logic [2:0]                       HSIZE,
    input  logic [1:0]                       HTRANS,
    input  logic                             HREADY,
    input  logic [DATA_WIDTH-1:0]            HWDATA,
    output logic                             HREADYOUT,
    output logic                             HRESP,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
`ifdef AHB2APB_PSTRB_EN
    ,
    output logic [DATA_WIDTH/8-1:0]          PSTRB
`endif
);

    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int SB = DATA_WIDTH / 8;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(SB));
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE, SETUP, ACCESS, DONE, ERR1, ERR2
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   hidx;
    logic [CW-1:0]   cnt, cnt_n;
    logic            valid, capture, bad, tmo;
    logic            sel_rdy, sel_err;
    logic [NUM_SLAVES-1:0] onehot;
    logic [DATA_WIDTH-1:0] prd [NUM_SLAVES];

    if (NUM_SLAVES > 1) begin : g_idx
        assign hidx = HADDR[SEL_LSB +: IW];
    end else begin : g_idx1
        assign hidx = '0;
    end

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_prd
        assign prd[i] = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign valid   = HSEL & HREADY & HTRANS[1];
    assign capture = valid & HREADYOUT;
    assign bad     = (5'(hidx) >= 5'(NUM_SLAVES)) | (HSIZE > MAX_SIZE);
    assign sel_rdy = PREADY[idx_q];
    assign sel_err = PSLVERR[idx_q];
    assign onehot  = NUM_SLAVES'(1) << idx_q;
    assign cnt_n   = (cnt == '1) ? cnt : cnt + 1'b1;

    // cnt_n counts the current ACCESS cycle, so the limit is reached on the last allowed one
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
        assign tmo = (cnt_n == CW'(TIMEOUT_CYCLES));
    end else begin : g_notmo
        assign tmo = 1'b0;
    end

    always_comb begin
        state_n   = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        PSEL      = '0;
        PENABLE   = 1'b0;
        unique case (state)
            IDLE, DONE, ERR2: begin
                HRESP = (state == ERR2);
                if (valid) state_n = bad ? ERR1 : SETUP;
                else       state_n = IDLE;
            end
            SETUP: begin
                HREADYOUT = 1'b0;
                PSEL      = onehot;
                state_n   = ACCESS;
            end
            ACCESS: begin
                HREADYOUT = 1'b0;
                PSEL      = onehot;
                PENABLE   = 1'b1;
                if (sel_rdy)  state_n = sel_err ? ERR1 : DONE;
                else if (tmo) state_n = ERR1;
            end
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_n   = ERR2;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state  <= IDLE;
            idx_q  <= '0;
            cnt    <= '0;
            HRDATA <= '0;
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
        end else begin
            state <= state_n;
            if (capture) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
                idx_q  <= hidx;
            end
            if (state == SETUP) begin
                PWDATA <= HWDATA;
                cnt    <= '0;
            end
            if (state == ACCESS) begin
                cnt <= cnt_n;
                if (sel_rdy & ~sel_err & ~PWRITE) HRDATA <= prd[idx_q];
            end
        end
    end

`ifdef AHB2APB_PSTRB_EN
    logic [2:0]    size_q;
    logic [SB-1:0] lanes;

    always_comb begin
        lanes = '0;
        for (int i = 0; i < SB; i++)
            lanes[i] = ((i >> size_q) == (int'(PADDR[$clog2(SB)-1:0]) >> size_q));
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            size_q <= '0;
            PSTRB  <= '0;
        end else begin
            if (capture) size_q <= HSIZE;
            if (state == SETUP) PSTRB <= PWRITE ? lanes : '0;
        end
    end
`endif

endmodule

// File: tb/tb_ahb2apb_bridge_nch.sv
// Bench for ahb2apb_bridge_nch: directed spec cases plus random transfers
// against a transaction-level response/latency model and a memory scoreboard.
module tb_ahb2apb_bridge_nch;

    logic        clk;
    logic        rst;
    logic        hsel, hsel3, hwrite, sel3;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    wire         hready;

    logic        hreadyout, hresp, penable, pwrite;
    logic [31:0] hrdata, paddr, pwdata;
    logic [3:0]  psel, pready, pslverr;
    logic [127:0] prdata;

    logic        hreadyout3, hresp3, penable3, pwrite3;
    logic [31:0] hrdata3, paddr3, pwdata3;
    logic [2:0]  psel3;

    int checks, errors;

    logic [31:0] mem     [4][16];
    logic [31:0] exp_mem [4][16];
    logic [31:0] hrdata_m;
    logic [7:0]  cnt  [4];
    logic [7:0]  wcfg [4];
    logic        ecfg [4];
    bit          loaded;

    assign hready = sel3 ? hreadyout3 : hreadyout;

    ahb2apb_bridge_nch dut (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HTRANS(htrans),
        .HREADY(hready), .HWDATA(hwdata), .HREADYOUT(hreadyout),
        .HRESP(hresp), .HRDATA(hrdata), .PSEL(psel),
        .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
        .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
        .PSLVERR(pslverr)
    );

    ahb2apb_bridge_nch #(.NUM_SLAVES(3)) dut3 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr),
        .HWRITE(hwrite), .HSIZE(hsize), .HTRANS(htrans),
        .HREADY(hready), .HWDATA(hwdata), .HREADYOUT(hreadyout3),
        .HRESP(hresp3), .HRDATA(hrdata3), .PSEL(psel3),
        .PENABLE(penable3), .PADDR(paddr3), .PWRITE(pwrite3),
        .PWDATA(pwdata3), .PRDATA({3{32'h3333_0000}}),
        .PREADY(3'b111), .PSLVERR(3'b000)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dflt(int i, int w);
        return (i == 3 && w == 0) ? 32'h1234_5678
                                  : (32'hC0DE_0000 | 32'(i << 8) | 32'(w));
    endfunction

    // APB slave bank: per-slave wait/err config, noise on unselected slaves
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4; i++)
                for (int w = 0; w < 16; w++) mem[i][w] <= dflt(i, w);
            loaded <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++)
                if (psel[i] & penable & pready[i] & ~pslverr[i] & pwrite)
                    mem[i][paddr[5:2]] <= pwdata;
        end
        for (int i = 0; i < 4; i++)
            cnt[i] <= (psel[i] & penable) ? ((cnt[i] == 8'hff) ? cnt[i] : cnt[i] + 8'd1) : 8'd0;
    end

    always_comb begin
        prdata  = '0;
        pready  = '0;
        pslverr = '0;
        for (int i = 0; i < 4; i++) begin
            prdata[i*32 +: 32] = mem[i][paddr[5:2]];
            if (psel[i] & penable) begin
                pready[i]  = (cnt[i] >= wcfg[i]);
                pslverr[i] = (cnt[i] >= wcfg[i]) & ecfg[i];
            end else begin
                pready[i]  = 1'b1;
                pslverr[i] = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input bit t3, input logic [31:0] a, input logic wr,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output int waits, output logic resp, output logic [31:0] rd,
                        output int acc, output int hrc,
                        output logic [3:0] por, output logic [3:0] pend);
        logic ro, rs, pe;
        logic [3:0] pv;
        waits = 0; acc = 0; hrc = 0; por = '0; pend = '0; resp = 1'b0; rd = '0;
        sel3 = t3;
        @(posedge clk) #1;
        if (t3) hsel3 = 1'b1; else hsel = 1'b1;
        htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
        @(posedge clk) #1;
        hsel = 1'b0; hsel3 = 1'b0; htrans = 2'b00; hwdata = wd;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            ro = t3 ? hreadyout3 : hreadyout;
            rs = t3 ? hresp3 : hresp;
            pv = t3 ? {1'b0, psel3} : psel;
            pe = t3 ? penable3 : penable;
            por |= pv;
            acc += int'(pe);
            hrc += int'(rs);
            if (ro) begin
                resp = rs;
                rd   = t3 ? hrdata3 : hrdata;
                pend = pv;
                break;
            end
            waits++;
            @(posedge clk) #1;
            hwdata = ~wd;
        end
    endtask

    task automatic run(input string tag, input bit t3, input int slv, input int word,
                       input logic [1:0] lo, input logic wr, input logic [2:0] sz,
                       input int w, input bit e, input logic [31:0] wd);
        int waits, acc, hrc, ew, eacc, ehrc;
        logic resp, eresp;
        logic [31:0] rd, a;
        logic [3:0] por, pend, epor;
        bit legal;
        if (!t3) begin
            wcfg[slv] = 8'(w);
            ecfg[slv] = e;
        end
        a = (32'(slv) << 12) | (32'(word) << 2) | 32'(lo);
        xfer(t3, a, wr, sz, wd, waits, resp, rd, acc, hrc, por, pend);
        legal = (slv < (t3 ? 3 : 4)) && (sz <= 3'd2);
        epor  = legal ? 4'(1 << slv) : 4'b0;
        if (!legal) begin
            ew = 1; eresp = 1'b1; eacc = 0; ehrc = 2;
        end else if (w >= 16) begin
            ew = 18; eresp = 1'b1; eacc = 16; ehrc = 2;
        end else if (e) begin
            ew = w + 3; eresp = 1'b1; eacc = w + 1; ehrc = 2;
        end else begin
            ew = w + 2; eresp = 1'b0; eacc = w + 1; ehrc = 0;
            if (!t3) begin
                if (wr) exp_mem[slv][word] = wd;
                else    hrdata_m = exp_mem[slv][word];
            end
        end
        chk({tag, ".waits"}, 64'(waits), 64'(ew));
        chk({tag, ".hresp"}, 64'(resp), 64'(eresp));
        chk({tag, ".access_cycles"}, 64'(acc), 64'(eacc));
        chk({tag, ".err_cycles"}, 64'(hrc), 64'(ehrc));
        chk({tag, ".psel_seen"}, 64'(por), 64'(epor));
        chk({tag, ".psel_at_end"}, 64'(pend), 64'(0));
        chk({tag, ".hrdata"}, 64'(rd), 64'(t3 ? 32'h0 : hrdata_m));
        for (int i = 0; i < 4; i++) begin
            wcfg[i] = 8'd0;
            ecfg[i] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mism;
        checks = 0; errors = 0;
        hsel = 0; hsel3 = 0; sel3 = 0; hwrite = 0; haddr = '0; hwdata = '0;
        hsize = 3'd2; htrans = 2'b00;
        hrdata_m = '0;
        for (int i = 0; i < 4; i++) begin
            wcfg[i] = 8'd0;
            ecfg[i] = 1'b0;
            for (int w = 0; w < 16; w++) exp_mem[i][w] = dflt(i, w);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.hreadyout", 64'(hreadyout), 64'(1));
        chk("rst.hresp", 64'(hresp), 64'(0));
        chk("rst.hrdata", 64'(hrdata), 64'(0));
        chk("rst.psel", 64'(psel), 64'(0));
        chk("rst.penable", 64'(penable), 64'(0));
        chk("rst.paddr", 64'(paddr), 64'(0));
        chk("rst.pwrite", 64'(pwrite), 64'(0));
        chk("rst.pwdata", 64'(pwdata), 64'(0));
        rst = 1'b0;

        @(posedge clk) #1;
        hsel = 1; htrans = 2'b10; haddr = 32'h0000_1004; hwrite = 1; hsize = 3'd2;
        @(posedge clk) #1;
        hsel = 0; htrans = 2'b00; hwdata = 32'hA5A5_0001;
        @(negedge clk);
        chk("w1.setup_psel", 64'(psel), 64'(4'b0010));
        chk("w1.setup_penable", 64'(penable), 64'(0));
        chk("w1.setup_hreadyout", 64'(hreadyout), 64'(0));
        @(posedge clk) #1;
        hwdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("w1.access_penable", 64'(penable), 64'(1));
        chk("w1.access_psel", 64'(psel), 64'(4'b0010));
        chk("w1.access_pwdata", 64'(pwdata), 64'(32'hA5A5_0001));
        chk("w1.access_hreadyout", 64'(hreadyout), 64'(0));
        @(negedge clk);
        chk("w1.done_hreadyout", 64'(hreadyout), 64'(1));
        chk("w1.done_hresp", 64'(hresp), 64'(0));
        chk("w1.done_psel", 64'(psel), 64'(0));
        chk("w1.done_penable", 64'(penable), 64'(0));
        exp_mem[1][1] = 32'hA5A5_0001;
        @(negedge clk);
        chk("w1.paddr_hold", 64'(paddr), 64'(32'h0000_1004));
        chk("w1.pwrite_hold", 64'(pwrite), 64'(1));

        run("rd_wait2", 0, 3, 0, 2'b00, 1'b0, 3'd2, 2, 0, 32'h0);
        chk("rd_wait2.value", 64'(hrdata), 64'(32'h1234_5678));
        run("wr_slverr", 0, 2, 0, 2'b00, 1'b1, 3'd2, 0, 1, 32'hDEAD_0002);
        run("rd_timeout", 0, 0, 0, 2'b00, 1'b0, 3'd2, 255, 0, 32'h0);
        run("bad_size", 0, 1, 2, 2'b00, 1'b1, 3'd3, 0, 0, 32'h0BAD_0003);
        run("n3_miss", 1, 3, 0, 2'b00, 1'b0, 3'd2, 0, 0, 32'h0);
        run("n3_write", 1, 2, 0, 2'b00, 1'b1, 3'd2, 0, 0, 32'hBEEF_0003);
        chk("n3.paddr", 64'(paddr3), 64'(32'h0000_2000));
        chk("n3.pwdata", 64'(pwdata3), 64'(32'hBEEF_0003));
        chk("n3.pwrite", 64'(pwrite3), 64'(1));
        sel3 = 0;

        @(posedge clk) #1;
        hsel = 1; htrans = 2'b01; haddr = 32'h0000_1000;
        @(negedge clk);
        chk("busy.hreadyout", 64'(hreadyout), 64'(1));
        @(posedge clk) #1;
        htrans = 2'b00;
        @(negedge clk);
        chk("busy.psel", 64'(psel), 64'(0));
        chk("busy.hresp", 64'(hresp), 64'(0));
        @(posedge clk) #1;
        hsel = 0;

        @(posedge clk) #1;
        hsel = 1; htrans = 2'b10; haddr = 32'h0000_0008; hwrite = 1; hsize = 3'd2;
        @(posedge clk) #1;
        hwrite = 0; hwdata = 32'h0B2B_0001;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (hreadyout) break;
            n++;
        end
        chk("b2b.first_waits", 64'(n), 64'(2));
        @(posedge clk) #1;
        hsel = 0; htrans = 2'b00; hwdata = 32'h5555_5555;
        @(negedge clk);
        chk("b2b.setup_psel", 64'(psel), 64'(4'b0001));
        chk("b2b.setup_pwrite", 64'(pwrite), 64'(0));
        n = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (hreadyout) break;
            n++;
        end
        exp_mem[0][2] = 32'h0B2B_0001;
        hrdata_m = exp_mem[0][2];
        chk("b2b.second_waits", 64'(n), 64'(2));
        chk("b2b.hrdata", 64'(hrdata), 64'(hrdata_m));
        chk("b2b.hresp", 64'(hresp), 64'(0));

        for (int k = 0; k < 40; k++) begin
            int s, wdx, w;
            bit e;
            logic [2:0] sz;
            logic [1:0] lo;
            s   = $urandom_range(0, 3);
            wdx = $urandom_range(0, 15);
            sz  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            lo  = 2'($urandom_range(0, 3));
            if (sz == 3'd1) lo[0] = 1'b0;
            if (sz >= 3'd2) lo = 2'b00;
            w = ($urandom_range(0, 19) == 0) ? 255 : $urandom_range(0, 3);
            e = ($urandom_range(0, 7) == 0);
            run($sformatf("rnd%0d", k), 0, s, wdx, lo, 1'($urandom_range(0, 1)),
                sz, w, e, $urandom);
        end

        mism = 0;
        for (int i = 0; i < 4; i++)
            for (int w = 0; w < 16; w++)
                if (mem[i][w] !== exp_mem[i][w]) mism++;
        chk("mem_sweep", 64'(mism), 64'(0));

        wcfg[0] = 8'd255;
        @(posedge clk) #1;
        hsel = 1; htrans = 2'b10; haddr = 32'h0000_0000; hwrite = 0; hsize = 3'd2;
        @(posedge clk) #1;
        hsel = 0; htrans = 2'b00;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid.in_access", 64'(penable), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid.psel", 64'(psel), 64'(0));
        chk("rst_mid.penable", 64'(penable), 64'(0));
        chk("rst_mid.hreadyout", 64'(hreadyout), 64'(1));
        chk("rst_mid.hrdata", 64'(hrdata), 64'(0));
        rst = 1'b0;
        wcfg[0] = 8'd0;
        hrdata_m = '0;
        run("post_rst", 0, 1, 1, 2'b00, 1'b0, 3'd2, 1, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
